// File: rtl/morse_encoder_if.sv
// -----------------------------------------------------------------------------
// morse_encoder_if
// Character handshake and key-output bundle between a character source and
// the Morse encoder.
//   char_in     source -> encoder  ASCII character to send
//   char_valid  source -> encoder  char_in is valid
//   char_ready  encoder -> source  encoder can accept a character
//   key_out     encoder -> source  Morse key, 1 = mark, 0 = space
//   busy        encoder -> source  a character or gap is in progress
//   err         encoder -> source  one-cycle pulse on an unsupported character
// Modports: master = character source, slave = encoder.
// -----------------------------------------------------------------------------
interface morse_encoder_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready,
        input  key_out,
        input  busy,
        input  err
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready,
        output key_out,
        output busy,
        output err
    );
endinterface

// File: rtl/morse_encoder.sv
// -----------------------------------------------------------------------------
// morse_encoder
// Transmit side of the Morse path. Takes one ASCII character per valid/ready
// handshake and keys it out with ITU timing: dot 1u, dash 3u, element gap 1u,
// character gap 3u, word gap 7u, where u = UNIT_CYCLES clock cycles.
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of morse_encoder_if (char_in, char_valid in;
//          char_ready, key_out, busy, err out, all registered)
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse time unit (>= 1)
// Configuration macro:
//   MORSE_ENC_DIGITS_EN  when defined, digits 0-9 are sent as 5-element codes;
//                        otherwise they are rejected like any other
//                        unsupported character.
// -----------------------------------------------------------------------------
module morse_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    morse_encoder_if.slave  bus
);

    localparam int CW = $clog2(UNIT_CYCLES + 1);
`ifdef MORSE_ENC_DIGITS_EN
    localparam int PW = 5;
`else
    localparam int PW = 4;
`endif

    localparam logic [1:0] K_SYM   = 2'd0;
    localparam logic [1:0] K_SPACE = 2'd1;
    localparam logic [1:0] K_BAD   = 2'd2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MARK     = 3'd1;
    localparam logic [2:0] S_ELEM_GAP = 3'd2;
    localparam logic [2:0] S_CHAR_GAP = 3'd3;
    localparam logic [2:0] S_WORD_GAP = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    // Returns {kind, length, pattern}; the pattern is left-aligned so the
    // MSB is always the next element to send (1 = dash).
    function automatic logic [PW+4:0] lookup(input logic [7:0] ch);
        logic [7:0]    c;
        logic [3:0]    p4;
        logic [2:0]    len;
        logic [1:0]    kind;
        logic [PW-1:0] pat;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            c = ch - 8'h20;
        end else begin
            c = ch;
        end
        kind = K_SYM;
        len  = 3'd0;
        p4   = 4'b0000;
        case (c)
            8'h41: begin len = 3'd2; p4 = 4'b0100; end // A .-
            8'h42: begin len = 3'd4; p4 = 4'b1000; end // B -...
            8'h43: begin len = 3'd4; p4 = 4'b1010; end // C -.-.
            8'h44: begin len = 3'd3; p4 = 4'b1000; end // D -..
            8'h45: begin len = 3'd1; p4 = 4'b0000; end // E .
            8'h46: begin len = 3'd4; p4 = 4'b0010; end // F ..-.
            8'h47: begin len = 3'd3; p4 = 4'b1100; end // G --.
            8'h48: begin len = 3'd4; p4 = 4'b0000; end // H ....
            8'h49: begin len = 3'd2; p4 = 4'b0000; end // I ..
            8'h4A: begin len = 3'd4; p4 = 4'b0111; end // J .---
            8'h4B: begin len = 3'd3; p4 = 4'b1010; end // K -.-
            8'h4C: begin len = 3'd4; p4 = 4'b0100; end // L .-..
            8'h4D: begin len = 3'd2; p4 = 4'b1100; end // M --
            8'h4E: begin len = 3'd2; p4 = 4'b1000; end // N -.
            8'h4F: begin len = 3'd3; p4 = 4'b1110; end // O ---
            8'h50: begin len = 3'd4; p4 = 4'b0110; end // P .--.
            8'h51: begin len = 3'd4; p4 = 4'b1101; end // Q --.-
            8'h52: begin len = 3'd3; p4 = 4'b0100; end // R .-.
            8'h53: begin len = 3'd3; p4 = 4'b0000; end // S ...
            8'h54: begin len = 3'd1; p4 = 4'b1000; end // T -
            8'h55: begin len = 3'd3; p4 = 4'b0010; end // U ..-
            8'h56: begin len = 3'd4; p4 = 4'b0001; end // V ...-
            8'h57: begin len = 3'd3; p4 = 4'b0110; end // W .--
            8'h58: begin len = 3'd4; p4 = 4'b1001; end // X -..-
            8'h59: begin len = 3'd4; p4 = 4'b1011; end // Y -.--
            8'h5A: begin len = 3'd4; p4 = 4'b1100; end // Z --..
            8'h20: kind = K_SPACE;
            default: kind = K_BAD;
        endcase
`ifdef MORSE_ENC_DIGITS_EN
        pat = {p4, 1'b0};
        if (c >= 8'h30 && c <= 8'h39) begin
            kind = K_SYM;
            len  = 3'd5;
            // 1-5: n dots then dashes; 6-9: (n-5) dashes then dots; 0: all dashes
            if (c == 8'h30) begin
                pat = 5'b11111;
            end else if (c <= 8'h35) begin
                pat = 5'b11111 >> (c[3:0]);
            end else begin
                pat = 5'b11111 << (4'd10 - c[3:0]);
            end
        end else begin
            pat = {p4, 1'b0};
        end
`else
        pat = p4;
`endif
        return {kind, len, pat};
    endfunction

    logic [2:0]    r_state;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_units;
    logic [2:0]    r_elems;
    logic [PW-1:0] r_pat;
    logic          r_key;
    logic          r_busy;
    logic          r_ready;
    logic          r_err;

    logic [PW+4:0] w_lut;
    logic [1:0]    w_kind;
    logic [2:0]    w_len;
    logic [PW-1:0] w_pat;
    logic          w_accept;
    logic          w_unit_done;
    logic          w_state_done;
    logic [2:0]    w_next_state;
    logic [2:0]    w_load_units;

    assign w_lut        = lookup(bus.char_in);
    assign w_kind       = w_lut[PW+4:PW+3];
    assign w_len        = w_lut[PW+2:PW];
    assign w_pat        = w_lut[PW-1:0];
    // r_ready is only ever high while the FSM sits in IDLE
    assign w_accept     = bus.char_valid & r_ready;
    assign w_unit_done  = (r_cyc == '0);
    assign w_state_done = w_unit_done && (r_units == 3'd0);

    // Next-state decode and the unit count (minus one) for the state entered
    always_comb begin
        w_next_state = r_state;
        w_load_units = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_kind == K_SYM) begin
                        w_next_state = S_MARK;
                        w_load_units = w_pat[PW-1] ? 3'd2 : 3'd0;
                    end else if (w_kind == K_SPACE) begin
                        w_next_state = S_WORD_GAP;
                        w_load_units = 3'd6;
                    end else begin
                        w_next_state = S_ERR;
                        w_load_units = 3'd0;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MARK: begin
                if (w_state_done) begin
                    if (r_elems > 3'd1) begin
                        w_next_state = S_ELEM_GAP;
                        w_load_units = 3'd0;
                    end else begin
                        w_next_state = S_CHAR_GAP;
                        w_load_units = 3'd2;
                    end
                end else begin
                    w_next_state = S_MARK;
                end
            end
            S_ELEM_GAP: begin
                if (w_state_done) begin
                    // pattern was already shifted when the previous mark ended
                    w_next_state = S_MARK;
                    w_load_units = r_pat[PW-1] ? 3'd2 : 3'd0;
                end else begin
                    w_next_state = S_ELEM_GAP;
                end
            end
            S_CHAR_GAP, S_WORD_GAP: begin
                if (w_state_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_ERR: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and outputs decoded from the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_key   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_key   <= (w_next_state == S_MARK);
            r_busy  <= (w_next_state != S_IDLE);
            r_ready <= (w_next_state == S_IDLE);
            r_err   <= (w_next_state == S_ERR);
        end
    end

    // Unit timer: reloads on every state change, frozen while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc   <= '0;
            r_units <= 3'd0;
        end else if (w_next_state != r_state) begin
            r_cyc   <= CW'(UNIT_CYCLES - 1);
            r_units <= w_load_units;
        end else if (r_state == S_IDLE) begin
            r_cyc   <= r_cyc;
            r_units <= r_units;
        end else if (w_unit_done) begin
            r_cyc   <= CW'(UNIT_CYCLES - 1);
            r_units <= r_units - 3'd1;
        end else begin
            r_cyc   <= r_cyc - CW'(1);
            r_units <= r_units;
        end
    end

    // Element pattern and remaining-element count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pat   <= '0;
            r_elems <= 3'd0;
        end else if ((r_state == S_IDLE) && w_accept && (w_kind == K_SYM)) begin
            r_pat   <= w_pat;
            r_elems <= w_len;
        end else if ((r_state == S_MARK) && w_state_done) begin
            r_pat   <= r_pat << 1;
            r_elems <= r_elems - 3'd1;
        end else begin
            r_pat   <= r_pat;
            r_elems <= r_elems;
        end
    end

    assign bus.char_ready = r_ready;
    assign bus.key_out    = r_key;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_encoder
// Table-driven bench for morse_encoder with UNIT_CYCLES = 4. Each record
// holds a character and its expected Morse code written as dots/dashes; the
// expected key waveform, busy length, ready cycle and err pulse are derived
// from that text. Hand-written sequences cover reset, back-to-back and
// mid-character reset. Sample n = value seen just before clock edge n,
// where edge 0 is the accept edge.
// -----------------------------------------------------------------------------
module tb_morse_encoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    morse_encoder_if bus ();

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] ch;
        logic [1:0] kind;   // 0 = symbol, 1 = space, 2 = unsupported
        logic [2:0] n;      // number of elements
        logic [7:0] dash;   // bit i set = element i is a dash
    } vec_t;

    localparam int NV = 18;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic [1:0] k, input string s);
        vec_t v;
        v.ch   = c;
        v.kind = k;
        v.n    = 3'(s.len());
        v.dash = 8'h00;
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == 8'h2D) v.dash[i] = 1'b1;
        end
        return v;
    endfunction

    // Expected key bits (bit n = sample n), busy count, ready sample, err bits
    task automatic build(input vec_t v, output logic [127:0] k, output int busy,
                         output int rdy, output logic [127:0] e);
        int pos;
        int len;
        k = '0;
        e = '0;
        busy = 0;
        rdy = 0;
        if (v.kind == 2'd0) begin
            pos = 1;
            for (int i = 0; i < int'(v.n); i++) begin
                len = v.dash[i] ? 12 : 4;
                for (int j = 0; j < len; j++) k[pos + j] = 1'b1;
                pos += len;
                if (i < int'(v.n) - 1) pos += 4;
            end
            pos += 12;
            busy = pos - 1;
            rdy  = pos;
        end else if (v.kind == 2'd1) begin
            busy = 28;
            rdy  = 29;
        end else begin
            busy = 1;
            rdy  = 2;
            e[1] = 1'b1;
        end
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (bus.char_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait_timeout", 128'(g >= 200), 128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        logic [127:0] ek, ee, ak, ae;
        int eb, er, ab, ar;
        string tag;
        build(v, ek, eb, er, ee);
        wait_ready();
        bus.char_in    = v.ch;
        bus.char_valid = 1'b1;
        @(posedge clk);
        ak = '0;
        ae = '0;
        ab = 0;
        ar = 0;
        for (int s = 1; s <= 120; s++) begin
            @(negedge clk);
            if (s == 1) bus.char_valid = 1'b0;
            ak[s] = bus.key_out;
            ae[s] = bus.err;
            if (bus.busy === 1'b1) ab++;
            if (bus.char_ready === 1'b1) begin
                ar = s;
                break;
            end
        end
        tag = $sformatf("%02h", v.ch);
        check({"key_", tag}, ak, ek);
        check({"busy_len_", tag}, 128'(ab), 128'(eb));
        check({"ready_at_", tag}, 128'(ar), 128'(er));
        check({"err_", tag}, ae, ee);
    endtask

    vec_t vecs [NV];

    initial begin
        int first_mark;
        logic busy29, ready29, key6;

        vecs[0]  = mk(8'h45, 2'd0, ".");     // E
        vecs[1]  = mk(8'h61, 2'd0, ".-");    // a
        vecs[2]  = mk(8'h54, 2'd0, "-");     // T
        vecs[3]  = mk(8'h4B, 2'd0, "-.-");   // K
        vecs[4]  = mk(8'h4F, 2'd0, "---");   // O
        vecs[5]  = mk(8'h71, 2'd0, "--.-");  // q
        vecs[6]  = mk(8'h7A, 2'd0, "--..");  // z
        vecs[7]  = mk(8'h68, 2'd0, "....");  // h
        vecs[8]  = mk(8'h41, 2'd0, ".-");    // A
        vecs[9]  = mk(8'h20, 2'd1, "");      // space
        vecs[10] = mk(8'h23, 2'd2, "");      // #
        vecs[11] = mk(8'h40, 2'd2, "");      // @ just below A
        vecs[12] = mk(8'h5B, 2'd2, "");      // [ just above Z
        vecs[13] = mk(8'h60, 2'd2, "");      // ` just below a
        vecs[14] = mk(8'h7B, 2'd2, "");      // { just above z
`ifdef MORSE_ENC_DIGITS_EN
        vecs[15] = mk(8'h35, 2'd0, "....."); // 5
        vecs[16] = mk(8'h30, 2'd0, "-----"); // 0
`else
        vecs[15] = mk(8'h35, 2'd2, "");      // 5
        vecs[16] = mk(8'h30, 2'd2, "");      // 0
`endif
        vecs[17] = mk(8'h5A, 2'd0, "--..");  // Z

        // Reset with a pending handshake that must be ignored
        rst_n          = 1'b0;
        bus.char_in    = 8'h45;
        bus.char_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key",   128'(bus.key_out),    128'(0));
        check("rst_busy",  128'(bus.busy),       128'(0));
        check("rst_err",   128'(bus.err),        128'(0));
        check("rst_ready", 128'(bus.char_ready), 128'(1));
        rst_n          = 1'b1;
        bus.char_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 128'(bus.busy), 128'(0));

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Space followed by T with char_valid held high through the word gap
        wait_ready();
        bus.char_in    = 8'h20;
        bus.char_valid = 1'b1;
        @(posedge clk);
        first_mark = 0;
        busy29     = 1'b1;
        ready29    = 1'b0;
        for (int s = 1; s <= 60; s++) begin
            @(negedge clk);
            if (s == 1) bus.char_in = 8'h54;
            if (s == 29) begin
                busy29  = bus.busy;
                ready29 = bus.char_ready;
            end
            if (bus.key_out === 1'b1) begin
                first_mark     = s;
                bus.char_valid = 1'b0;
                break;
            end
        end
        bus.char_valid = 1'b0;
        check("spaceT_first_mark", 128'(first_mark), 128'(30));
        check("spaceT_busy29",     128'(busy29),     128'(0));
        check("spaceT_ready29",    128'(ready29),    128'(1));

        // Reset sampled at edge 6 while 'O' is in its first dash
        wait_ready();
        bus.char_in    = 8'h4F;
        bus.char_valid = 1'b1;
        @(posedge clk);
        key6 = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            @(negedge clk);
            if (s == 1) bus.char_valid = 1'b0;
            if (s == 6) key6 = bus.key_out;
        end
        rst_n          = 1'b0;
        bus.char_in    = 8'h54;
        bus.char_valid = 1'b1;
        @(negedge clk);
        check("midrst_key6",  128'(key6),           128'(1));
        check("midrst_key",   128'(bus.key_out),    128'(0));
        check("midrst_busy",  128'(bus.busy),       128'(0));
        check("midrst_ready", 128'(bus.char_ready), 128'(1));
        rst_n          = 1'b1;
        bus.char_valid = 1'b0;
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
